instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter SIZE, default 16, address width; shall match the program counter width.
REQ-002 Parameter INSTR_W, default 16, instruction width.
REQ-003 Parameter PC_INC, default 2, address increment per sequential fetch.
REQ-004 clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 pcAddress  in  SIZE  current program counter value.
REQ-007 pcWrite  out  1  program counter load enable (combinational).
REQ-008 nextAddress  out  SIZE  value loaded into the program counter when pcWrite=1 (combinational).
REQ-009 branchTaken  in  1  single-cycle redirect request; branchTarget  in  SIZE  redirect address.
REQ-010 stall  in  1  decode cannot accept the held instruction this cycle.
REQ-011 memReq  out  1  instruction memory request; memAddr  out  SIZE  registered request address.
REQ-012 memAck  in  1  memory completion, 0..N cycles after memReq rises; memData  in  INSTR_W  valid when memAck=1.
REQ-013 instrOut  out  INSTR_W, pcOut  out  SIZE, instrValid  out  1: IF/ID register toward decode.

Function
REQ-014 FSM states are IDLE, FETCH, PEND and DISCARD; memReq shall be 1 exactly in FETCH and DISCARD.
REQ-015 IDLE -> FETCH on the first clock after reset release, loading memAddr <= pcAddress.
REQ-016 memAddr shall remain stable while memReq=1 and no memAck has arrived; a request, once issued, always completes.
REQ-017 Consumption: decode consumes the held instruction in any cycle with instrValid=1 and stall=0.
REQ-018 FETCH, memAck=1, branchTaken=0, slot free (instrValid=0 or stall=0): instrOut<=memData, pcOut<=memAddr, instrValid<=1, pcWrite=1, nextAddress=pcAddress+PC_INC, memAddr<=pcAddress+PC_INC; remain in FETCH (one fetch per cycle with a zero-wait memory).
REQ-019 FETCH, memAck=1, branchTaken=0, slot blocked (instrValid=1 and stall=1): memData and memAddr go to the pending buffer, pcWrite=1 with pcAddress+PC_INC, memAddr<=pcAddress+PC_INC; go to PEND.
REQ-020 PEND with stall=0 and branchTaken=0: pending contents move to instrOut/pcOut, instrValid stays 1; go to FETCH. PEND with stall=1 holds all state.
REQ-021 FETCH with memAck=0: instrValid<=0 when consumed; otherwise hold.
REQ-022 branchTaken=1 has priority over stall and memAck: pcWrite=1, nextAddress=branchTarget, instrValid<=0, pending buffer invalidated.
REQ-023 Branch in FETCH with memAck=1, or in PEND or IDLE: memAddr<=branchTarget, next state FETCH.
REQ-024 Branch in FETCH with memAck=0: memAddr unchanged, go to DISCARD; a further branch in DISCARD reloads the PC again and remains in DISCARD.
REQ-025 DISCARD with memAck=1: memData dropped, memAddr<=pcAddress, go to FETCH; instrValid shall stay 0 throughout DISCARD.
REQ-026 pcWrite shall be 0 in all cases not listed in REQ-018, REQ-019 and REQ-022.
REQ-027 Address arithmetic is modulo 2^SIZE; 0xFFFE+2 wraps to 0x0000 without error.

Reset
REQ-028 On reset low: state=IDLE, memAddr=0, instrOut=0, pcOut=0, instrValid=0, pending buffer cleared. memReq and pcWrite follow immediately to 0, independent of the clock.
REQ-029 Reset asserted mid-request shall abandon the request. The memory shares the same reset and shall not deliver a late memAck.

Structure
REQ-030 A shared package shall hold the FSM state type and the default constants SIZE, INSTR_W and PC_INC.
REQ-031 The pending buffer (data, address, valid) shall be one sub-module, fetch_skid_buffer; the FSM and the IF/ID register stay in the top module.

Verification
REQ-032 Zero-wait memory (memAck tied 1), PC from 0: instrValid rises cycle 2; pcOut steps 0,2,4,6 on consecutive cycles; pcWrite=1 each cycle.
REQ-033 memAck delayed 3 cycles at memAddr=0x0004: memAddr holds 0x0004 for 3 cycles, pcWrite=0 in those cycles, instruction captured on the 4th.
REQ-034 stall=1 with instrValid=1 when ack for 0x0008 arrives: state PEND, memReq=0, instrOut unchanged; after stall=0, instrOut=data(0x0008), pcOut=0x0008.
REQ-035 branchTaken=1, target 0x0100, while request for 0x0010 is outstanding: pcWrite=1 with nextAddress=0x0100; data(0x0010) never reaches instrOut; next memAddr=0x0100.
REQ-036 Reset pulse while in FETCH at 0x0020: memReq and instrValid go to 0 asynchronously; after release, fetch restarts at the PC value (0x0000).
REQ-037 PC=0xFFFE with a sequential fetch: nextAddress=0x0000.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared fetch FSM state type and default widths
package instruction_fetch_pkg;

  localparam int DEF_SIZE    = 16;
  localparam int DEF_INSTR_W = 16;
  localparam int DEF_PC_INC  = 2;

  // IDLE: out of reset; FETCH: request live; PEND: holding a blocked word;
  // DISCARD: request live but its data belongs to a squashed path
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PEND    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - instruction memory request/ack bus
interface instruction_fetch_if
  import instruction_fetch_pkg::*;
#(
  parameter int SIZE    = DEF_SIZE,
  parameter int INSTR_W = DEF_INSTR_W
);

  logic               memReq;
  logic [SIZE-1:0]    memAddr;
  logic               memAck;
  logic [INSTR_W-1:0] memData;

  modport master (output memReq, output memAddr, input memAck, input memData);
  modport slave  (input memReq, input memAddr, output memAck, output memData);

endinterface

// File: rtl/fetch_skid_buffer.sv
// rtl/fetch_skid_buffer.sv - one-entry pending buffer for a word decode cannot take yet
module fetch_skid_buffer
  import instruction_fetch_pkg::*;
#(
  parameter int SIZE    = DEF_SIZE,
  parameter int INSTR_W = DEF_INSTR_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] load_data,
  input  logic [SIZE-1:0]    load_addr,
  output logic [INSTR_W-1:0] data,
  output logic [SIZE-1:0]    addr,
  output logic               valid
);

  // Clear wins over load so a redirect always empties the buffer
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data  <= '0;
      addr  <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      addr  <= load_addr;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch FSM, PC sequencing and IF/ID register
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int SIZE    = DEF_SIZE,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int PC_INC  = DEF_PC_INC
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [SIZE-1:0]           pcAddress,
  output logic                      pcWrite,
  output logic [SIZE-1:0]           nextAddress,
  input  logic                      branchTaken,
  input  logic [SIZE-1:0]           branchTarget,
  input  logic                      stall,
  instruction_fetch_if.master       mem,
  output logic [INSTR_W-1:0]        instrOut,
  output logic [SIZE-1:0]           pcOut,
  output logic                      instrValid
);

  fetch_state_t       state, state_nxt;
  logic [SIZE-1:0]    mem_addr_q, mem_addr_d;
  logic [SIZE-1:0]    seq_addr;
  logic [SIZE-1:0]    next_addr_c;
  logic               pc_write_c;
  logic               consumed;
  logic               ifid_load_mem, ifid_load_pend, ifid_clear;
  logic               pend_load, pend_clear, pend_valid;
  logic [INSTR_W-1:0] pend_data;
  logic [SIZE-1:0]    pend_addr;

  // Sum truncates to SIZE bits, so the top of memory wraps to zero
  assign seq_addr = pcAddress + SIZE'(PC_INC);
  assign consumed = instrValid && !stall;

  // Gated by reset so both strobes drop the moment reset asserts
  assign mem.memReq  = reset && ((state == FETCH) || (state == DISCARD));
  assign mem.memAddr = mem_addr_q;
  assign pcWrite     = reset && pc_write_c;
  assign nextAddress = next_addr_c;

  fetch_skid_buffer #(.SIZE(SIZE), .INSTR_W(INSTR_W)) u_skid (
    .clock     (clock),
    .reset     (reset),
    .load      (pend_load),
    .clear     (pend_clear),
    .load_data (mem.memData),
    .load_addr (mem_addr_q),
    .data      (pend_data),
    .addr      (pend_addr),
    .valid     (pend_valid)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, PC load and datapath strobes; a redirect overrides everything
  always_comb begin
    state_nxt      = state;
    mem_addr_d     = mem_addr_q;
    pc_write_c     = 1'b0;
    next_addr_c    = seq_addr;
    ifid_load_mem  = 1'b0;
    ifid_load_pend = 1'b0;
    ifid_clear     = 1'b0;
    pend_load      = 1'b0;
    pend_clear     = 1'b0;
    if (branchTaken) begin
      pc_write_c  = 1'b1;
      next_addr_c = branchTarget;
      ifid_clear  = 1'b1;
      pend_clear  = 1'b1;
      if (((state == FETCH) || (state == DISCARD)) && !mem.memAck) begin
        // The live request must still complete at its original address
        state_nxt = DISCARD;
      end else begin
        mem_addr_d = branchTarget;
        state_nxt  = FETCH;
      end
    end else begin
      case (state)
        IDLE: begin
          mem_addr_d = pcAddress;
          state_nxt  = FETCH;
        end
        FETCH: begin
          if (mem.memAck) begin
            pc_write_c = 1'b1;
            mem_addr_d = seq_addr;
            if (instrValid && stall) begin
              pend_load = 1'b1;
              state_nxt = PEND;
            end else begin
              ifid_load_mem = 1'b1;
            end
          end else if (consumed) begin
            ifid_clear = 1'b1;
          end
        end
        PEND: begin
          if (!stall) begin
            ifid_load_pend = pend_valid;
            pend_clear     = 1'b1;
            state_nxt      = FETCH;
          end
        end
        DISCARD: begin
          if (mem.memAck) begin
            mem_addr_d = pcAddress;
            state_nxt  = FETCH;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Request address and IF/ID register toward decode
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_addr_q <= '0;
      instrOut   <= '0;
      pcOut      <= '0;
      instrValid <= 1'b0;
    end else begin
      mem_addr_q <= mem_addr_d;
      if (ifid_clear) begin
        instrValid <= 1'b0;
      end else if (ifid_load_mem) begin
        instrOut   <= mem.memData;
        pcOut      <= mem_addr_q;
        instrValid <= 1'b1;
      end else if (ifid_load_pend) begin
        instrOut   <= pend_data;
        pcOut      <= pend_addr;
        instrValid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - bench for instruction_fetch
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
  } ent_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pcAddress = '0;
  logic        pcWrite;
  logic [15:0] nextAddress;
  logic        branchTaken = 1'b0;
  logic [15:0] branchTarget = '0;
  logic        stall = 1'b0;
  logic [15:0] instrOut;
  logic [15:0] pcOut;
  logic        instrValid;

  instruction_fetch_if #(.SIZE(16), .INSTR_W(16)) mem_bus ();

  instruction_fetch #(.SIZE(16), .INSTR_W(16), .PC_INC(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .pcAddress    (pcAddress),
    .pcWrite      (pcWrite),
    .nextAddress  (nextAddress),
    .branchTaken  (branchTaken),
    .branchTarget (branchTarget),
    .stall        (stall),
    .mem          (mem_bus.master),
    .instrOut     (instrOut),
    .pcOut        (pcOut),
    .instrValid   (instrValid)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          failures = 0;
  ent_t        q[$];
  logic [15:0] pc;
  int          lat, wait_cnt, force_lat, consumed_cnt;
  bit          stale, prev_wait;
  logic [15:0] prev_addr;
  logic        s_req, s_ack, s_pcw;
  logic [15:0] s_addr, s_na;

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    logic [15:0] h;
    h = (a * 16'h9E37) ^ 16'h5A5A;
    return h;
  endfunction

  function automatic int pick();
    if (force_lat >= 0) return force_lat;
    return int'($urandom_range(0, 3));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pc = '0;
    q.delete();
    stale = 1'b0;
    wait_cnt = 0;
    lat = pick();
    prev_wait = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    branchTaken = 1'b1;
    branchTarget = 16'h1234;
    mem_bus.memAck = 1'b0;
    #1;
    chk("rst_memreq", mem_bus.memReq, 0);
    chk("rst_pcwrite", pcWrite, 0);
    chk("rst_valid", instrValid, 0);
    chk("rst_memaddr", mem_bus.memAddr, 0);
    chk("rst_pcout", pcOut, 0);
    chk("rst_instr", instrOut, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    branchTaken = 1'b0;
    model_reset();
  endtask

  task automatic cycle(input bit br, input logic [15:0] tgt, input bit st);
    ent_t e;
    bit   consume;
    bit   fresh;
    pcAddress = pc;
    branchTaken = br;
    branchTarget = tgt;
    stall = st;
    mem_bus.memAck = mem_bus.memReq && (wait_cnt >= lat);
    mem_bus.memData = mem_bus.memAck ? mem_f(mem_bus.memAddr) : 16'($urandom);
    #2;
    s_req = mem_bus.memReq;
    s_ack = mem_bus.memAck;
    s_addr = mem_bus.memAddr;
    s_pcw = pcWrite;
    s_na = nextAddress;
    fresh = s_req && s_ack && !stale;
    chk("pcwrite", s_pcw, br || fresh);
    if (br) chk("branch_next", s_na, tgt);
    else if (s_pcw) chk("seq_next", s_na, 16'(pc + 16'd2));
    if (fresh) chk("fetch_addr", s_addr, pc);
    if (prev_wait) begin
      chk("req_hold", s_req, 1);
      chk("addr_hold", s_addr, prev_addr);
    end
    consume = instrValid && !st;
    @(posedge clock);
    #1;
    if (consume) begin
      consumed_cnt++;
      if (q.size() > 0) void'(q.pop_front());
    end
    if (br) q.delete();
    else if (fresh) begin
      e.a = s_addr;
      e.d = mem_f(s_addr);
      q.push_back(e);
    end
    if (s_req) begin
      if (s_ack) begin
        stale = 1'b0;
        wait_cnt = 0;
        lat = pick();
      end else begin
        if (br) stale = 1'b1;
        wait_cnt++;
      end
    end
    prev_wait = s_req && !s_ack;
    prev_addr = s_addr;
    if (s_pcw) pc = s_na;
    chk("valid", instrValid, q.size() != 0);
    if (q.size() > 0) begin
      chk("pc_out", pcOut, q[0].a);
      chk("instr_out", instrOut, q[0].d);
    end
    chk("mem_req", mem_bus.memReq, q.size() != 2);
  endtask

  initial begin
    bit seen10, acked;
    force_lat = 0;
    consumed_cnt = 0;
    #1;
    do_reset();

    // zero-wait streaming from 0
    cycle(0, 16'h0, 0);
    cycle(0, 16'h0, 0);
    chk("z_valid_c2", instrValid, 1);
    chk("z_pcout0", pcOut, 0);
    for (int k = 1; k <= 3; k++) begin
      cycle(0, 16'h0, 0);
      chk("z_pcwrite", s_pcw, 1);
      chk("z_pcout", pcOut, 2 * k);
    end

    // three wait states at 0x0004
    force_lat = 3;
    cycle(1, 16'h0004, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 16'h0, 0);
      chk("w_addr", s_addr, 16'h0004);
      chk("w_pcwrite", s_pcw, 0);
    end
    force_lat = 0;
    cycle(0, 16'h0, 0);
    chk("w_ack_pcwrite", s_pcw, 1);
    chk("w_instr", instrOut, mem_f(16'h0004));
    chk("w_pcout", pcOut, 16'h0004);

    // stall while the word for 0x0008 returns
    cycle(0, 16'h0, 0);
    cycle(0, 16'h0, 1);
    chk("p_addr", s_addr, 16'h0008);
    chk("p_state", 32'(dut.state), 32'(PEND));
    chk("p_memreq", mem_bus.memReq, 0);
    chk("p_instr_held", instrOut, mem_f(16'h0006));
    cycle(0, 16'h0, 1);
    chk("p_hold", instrOut, mem_f(16'h0006));
    cycle(0, 16'h0, 0);
    chk("p_instr", instrOut, mem_f(16'h0008));
    chk("p_pcout", pcOut, 16'h0008);

    // redirect while the 0x0010 request is outstanding
    force_lat = 3;
    cycle(1, 16'h0010, 0);
    cycle(0, 16'h0, 0);
    cycle(1, 16'h0100, 0);
    chk("b_pcwrite", s_pcw, 1);
    chk("b_next", s_na, 16'h0100);
    force_lat = 0;
    seen10 = 0;
    acked = 0;
    for (int i = 0; i < 6 && !acked; i++) begin
      cycle(0, 16'h0, 0);
      acked = s_ack;
      if (instrValid && pcOut == 16'h0010) seen10 = 1;
    end
    chk("b_ack_bounded", acked, 1);
    chk("b_memaddr", mem_bus.memAddr, 16'h0100);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 16'h0, 0);
      if (instrValid && pcOut == 16'h0010) seen10 = 1;
    end
    chk("b_no_stale", seen10, 0);

    // reset pulse while fetching 0x0020
    cycle(1, 16'h001E, 0);
    force_lat = 3;
    cycle(0, 16'h0, 0);
    cycle(0, 16'h0, 1);
    chk("r_addr", mem_bus.memAddr, 16'h0020);
    chk("r_valid_before", instrValid, 1);
    force_lat = 0;
    do_reset();
    cycle(0, 16'h0, 0);
    chk("r_restart_addr", mem_bus.memAddr, 16'h0000);
    cycle(0, 16'h0, 0);
    chk("r_restart_pcout", pcOut, 16'h0000);

    // wrap at the top of the address space
    cycle(1, 16'hFFFC, 0);
    cycle(0, 16'h0, 0);
    cycle(0, 16'h0, 0);
    chk("wrap_pc", s_addr, 16'hFFFE);
    chk("wrap_next", s_na, 16'h0000);
    cycle(0, 16'h0, 0);
    chk("wrap_addr", s_addr, 16'h0000);

    // random traffic against the scoreboard
    force_lat = -1;
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 9) == 0, 16'($urandom) & 16'hFFFE, $urandom_range(0, 2) == 0);
    end
    chk("progress", consumed_cnt > 50, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
